mat_job_sequencer: RTL

MAT_JOB_SEQUENCER -- requirements
Module: mat_job_sequencer

---
 rtl/mat_job_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mat_job_sequencer.sv
// rtl/mat_job_sequencer.sv - UART packet sequencer for a 2x2 byte-matrix multiply job
module mat_job_sequencer #(
    parameter int MUL_LATENCY = 2,
    parameter int TIMEOUT     = 1200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    output logic [31:0] mat_a,
    output logic [31:0] mat_b,
    input  logic [31:0] mat_c,
    output logic        job_done,
    output logic        err,
    output logic        busy
);

    localparam int LAT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_CSUM,
        S_WAIT_B,
        S_COMPUTE,
        S_SEND,
        S_SEND_GAP
    } state_t;

    state_t state, state_next;

    // expect_b selects which matrix the packet in flight carries
    logic             expect_b;
    logic             hdr_cnt;
    logic [1:0]       item_cnt;
    logic [7:0]       csum;
    logic [7:0]       job_id;
    logic [31:0]      shadow;
    logic [LAT_W-1:0] lat_cnt;
    logic [2:0]       send_idx;
    logic [31:0]      result;
    logic [23:0]      idle_cnt;
    logic [7:0]       send_byte;
    logic             abort;
    logic             timeout_hit;
    logic             lat_done;

    // Timeout fires on the cycle the idle counter would reach TIMEOUT
    assign timeout_hit = !rx_valid && (idle_cnt == 24'(TIMEOUT - 1));
    assign lat_done    = (lat_cnt == LAT_W'(MUL_LATENCY - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and abort detection
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == 8'hFF) state_next = S_HDR;
            end
            S_HDR: begin
                if (timeout_hit) begin
                    abort = 1'b1;
                end else if (rx_valid) begin
                    if (!hdr_cnt) begin
                        if (rx_data != {7'd0, expect_b}) abort = 1'b1;
                    end else if (expect_b && rx_data != job_id) begin
                        abort = 1'b1;
                    end else begin
                        state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (timeout_hit) abort = 1'b1;
                else if (rx_valid && item_cnt == 2'd3) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (timeout_hit) begin
                    abort = 1'b1;
                end else if (rx_valid) begin
                    if (rx_data != csum) abort = 1'b1;
                    else state_next = expect_b ? S_COMPUTE : S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (timeout_hit) abort = 1'b1;
                else if (rx_valid && rx_data == 8'hFF) state_next = S_HDR;
            end
            S_COMPUTE: begin
                if (lat_done) state_next = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) state_next = S_SEND_GAP;
            end
            S_SEND_GAP: begin
                state_next = (send_idx == 3'd5) ? S_IDLE : S_SEND;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    // Output decode: busy flag and the next result byte to transmit
    always_comb begin
        busy = (state != S_IDLE);
        case (send_idx)
            3'd0:    send_byte = job_id;
            3'd1:    send_byte = result[7:0];
            3'd2:    send_byte = result[15:8];
            3'd3:    send_byte = result[23:16];
            3'd4:    send_byte = result[31:24];
            default: send_byte = 8'h00;
        endcase
    end

    // Datapath: packet capture, commit, result buffering and transmit pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expect_b <= 1'b0;
            hdr_cnt  <= 1'b0;
            item_cnt <= 2'd0;
            csum     <= 8'h00;
            job_id   <= 8'h00;
            shadow   <= 32'h0;
            lat_cnt  <= '0;
            send_idx <= 3'd0;
            result   <= 32'h0;
            idle_cnt <= 24'd0;
            mat_a    <= 32'h0;
            mat_b    <= 32'h0;
            tx_send  <= 1'b0;
            tx_data  <= 8'h00;
            job_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_send  <= 1'b0;
            job_done <= 1'b0;
            err      <= abort;
            if (rx_valid) idle_cnt <= 24'd0;
            else if (idle_cnt != 24'hFFFFFF) idle_cnt <= idle_cnt + 24'd1;

            if (abort) begin
                expect_b <= 1'b0;
                hdr_cnt  <= 1'b0;
                item_cnt <= 2'd0;
                csum     <= 8'h00;
                job_id   <= 8'h00;
                shadow   <= 32'h0;
            end else begin
                case (state)
                    S_IDLE, S_WAIT_B: begin
                        if (rx_valid && rx_data == 8'hFF) begin
                            expect_b <= (state == S_WAIT_B);
                            hdr_cnt  <= 1'b0;
                            item_cnt <= 2'd0;
                            csum     <= 8'h00;
                            shadow   <= 32'h0;
                        end
                    end
                    S_HDR: begin
                        if (rx_valid) begin
                            csum    <= csum + rx_data;
                            hdr_cnt <= 1'b1;
                            if (hdr_cnt && !expect_b) job_id <= rx_data;
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_valid) begin
                            csum                         <= csum + rx_data;
                            shadow[{item_cnt, 3'b000} +: 8] <= rx_data;
                            item_cnt                     <= item_cnt + 2'd1;
                        end
                    end
                    S_CSUM: begin
                        if (rx_valid && rx_data == csum) begin
                            if (expect_b) mat_b <= shadow;
                            else mat_a <= shadow;
                            shadow  <= 32'h0;
                            lat_cnt <= '0;
                        end
                    end
                    S_COMPUTE: begin
                        lat_cnt <= lat_cnt + 1'b1;
                        if (lat_done) begin
                            result   <= mat_c;
                            send_idx <= 3'd0;
                        end
                    end
                    S_SEND: begin
                        if (!tx_busy) begin
                            tx_send  <= 1'b1;
                            tx_data  <= send_byte;
                            send_idx <= send_idx + 3'd1;
                        end
                    end
                    S_SEND_GAP: begin
                        if (send_idx == 3'd5) job_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
